pipeline_front_regs: RTL and testbench

- Groups the first three inter-stage registers of the 5-stage MIPS pipeline (cpu_pipe): IF/ID, ID/EX and EX/MEM.
- Captures fetch, decode and execute results on each rising clock edge and presents them to the next stage.
- Supports an IF/ID hold for load-use stalls.
- Bubble insertion stays outside this block: upstream control is zeroed by the hazard mux before it reaches the ID/EX inputs.

---
 rtl/pipeline_front_regs_if.sv | 79 +++++++
 rtl/pipeline_front_regs.sv | 159 +++++++++++++++
 tb/tb_pipeline_front_regs.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_front_regs_if.sv
// Signal bundle for the IF/ID, ID/EX and EX/MEM pipeline registers.
// The master side is the surrounding datapath. The slave side is the register block.
interface pipeline_front_regs_if;
  // IF/ID
  logic [31:0] if_instruction;
  logic [31:0] if_pc4;
  logic        ifid_hold;
  logic [31:0] ifid_instruction;
  logic [31:0] ifid_pc4;

  // ID/EX
  logic        id_reg_write;
  logic        id_mem_to_reg;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_reg_dst;
  logic        id_alu_src;
  logic        id_branch;
  logic [1:0]  id_alu_op;
  logic [31:0] id_read_data1;
  logic [31:0] id_read_data2;
  logic        idex_reg_write;
  logic        idex_mem_to_reg;
  logic        idex_mem_read;
  logic        idex_mem_write;
  logic        idex_reg_dst;
  logic        idex_alu_src;
  logic        idex_branch;
  logic [1:0]  idex_alu_op;
  logic [31:0] idex_pc4;
  logic [31:0] idex_read_data1;
  logic [31:0] idex_read_data2;
  logic [15:0] idex_immediate;
  logic [4:0]  idex_rs;
  logic [4:0]  idex_rt;
  logic [4:0]  idex_rd;

  // EX/MEM
  logic [31:0] ex_alu_result;
  logic [31:0] ex_write_data;
  logic [4:0]  ex_dest_reg;
  logic        exmem_reg_write;
  logic        exmem_mem_to_reg;
  logic        exmem_mem_read;
  logic        exmem_mem_write;
  logic [31:0] exmem_alu_result;
  logic [31:0] exmem_write_data;
  logic [4:0]  exmem_dest_reg;

  modport master (
    output if_instruction, if_pc4, ifid_hold,
    output id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
    output id_reg_dst, id_alu_src, id_branch, id_alu_op,
    output id_read_data1, id_read_data2,
    output ex_alu_result, ex_write_data, ex_dest_reg,
    input  ifid_instruction, ifid_pc4,
    input  idex_reg_write, idex_mem_to_reg, idex_mem_read, idex_mem_write,
    input  idex_reg_dst, idex_alu_src, idex_branch, idex_alu_op,
    input  idex_pc4, idex_read_data1, idex_read_data2,
    input  idex_immediate, idex_rs, idex_rt, idex_rd,
    input  exmem_reg_write, exmem_mem_to_reg, exmem_mem_read, exmem_mem_write,
    input  exmem_alu_result, exmem_write_data, exmem_dest_reg
  );

  modport slave (
    input  if_instruction, if_pc4, ifid_hold,
    input  id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
    input  id_reg_dst, id_alu_src, id_branch, id_alu_op,
    input  id_read_data1, id_read_data2,
    input  ex_alu_result, ex_write_data, ex_dest_reg,
    output ifid_instruction, ifid_pc4,
    output idex_reg_write, idex_mem_to_reg, idex_mem_read, idex_mem_write,
    output idex_reg_dst, idex_alu_src, idex_branch, idex_alu_op,
    output idex_pc4, idex_read_data1, idex_read_data2,
    output idex_immediate, idex_rs, idex_rt, idex_rd,
    output exmem_reg_write, exmem_mem_to_reg, exmem_mem_read, exmem_mem_write,
    output exmem_alu_result, exmem_write_data, exmem_dest_reg
  );
endinterface

// File: rtl/pipeline_front_regs.sv
// IF/ID, ID/EX and EX/MEM registers of the 5-stage MIPS pipeline.
// All stages shift together on each rising edge. IF/ID can be held during a load-use stall.
module pipeline_front_regs (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_front_regs_if.slave  bus
);
  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int IMM_W   = 16;
  localparam int ALUOP_W = 2;

  logic [DATA_W-1:0]  ifid_instruction_d, ifid_instruction_q;
  logic [DATA_W-1:0]  ifid_pc4_d,         ifid_pc4_q;

  logic               idex_reg_write_d,   idex_reg_write_q;
  logic               idex_mem_to_reg_d,  idex_mem_to_reg_q;
  logic               idex_mem_read_d,    idex_mem_read_q;
  logic               idex_mem_write_d,   idex_mem_write_q;
  logic               idex_reg_dst_d,     idex_reg_dst_q;
  logic               idex_alu_src_d,     idex_alu_src_q;
  logic               idex_branch_d,      idex_branch_q;
  logic [ALUOP_W-1:0] idex_alu_op_d,      idex_alu_op_q;
  logic [DATA_W-1:0]  idex_pc4_d,         idex_pc4_q;
  logic [DATA_W-1:0]  idex_read_data1_d,  idex_read_data1_q;
  logic [DATA_W-1:0]  idex_read_data2_d,  idex_read_data2_q;
  logic [IMM_W-1:0]   idex_immediate_d,   idex_immediate_q;
  logic [REG_W-1:0]   idex_rs_d,          idex_rs_q;
  logic [REG_W-1:0]   idex_rt_d,          idex_rt_q;
  logic [REG_W-1:0]   idex_rd_d,          idex_rd_q;

  logic               exmem_reg_write_d,  exmem_reg_write_q;
  logic               exmem_mem_to_reg_d, exmem_mem_to_reg_q;
  logic               exmem_mem_read_d,   exmem_mem_read_q;
  logic               exmem_mem_write_d,  exmem_mem_write_q;
  logic [DATA_W-1:0]  exmem_alu_result_d, exmem_alu_result_q;
  logic [DATA_W-1:0]  exmem_write_data_d, exmem_write_data_q;
  logic [REG_W-1:0]   exmem_dest_reg_d,   exmem_dest_reg_q;

  // IF/ID stage: recirculate on hold so the stalled instruction is decoded again
  always_comb begin
    ifid_instruction_d = ifid_instruction_q;
    ifid_pc4_d         = ifid_pc4_q;
    if (!bus.ifid_hold) begin
      ifid_instruction_d = bus.if_instruction;
      ifid_pc4_d         = bus.if_pc4;
    end
  end

  // ID/EX stage: register fields are sliced from the IF/ID contents before the edge
  always_comb begin
    idex_reg_write_d  = bus.id_reg_write;
    idex_mem_to_reg_d = bus.id_mem_to_reg;
    idex_mem_read_d   = bus.id_mem_read;
    idex_mem_write_d  = bus.id_mem_write;
    idex_reg_dst_d    = bus.id_reg_dst;
    idex_alu_src_d    = bus.id_alu_src;
    idex_branch_d     = bus.id_branch;
    idex_alu_op_d     = bus.id_alu_op;
    idex_pc4_d        = ifid_pc4_q;
    idex_read_data1_d = bus.id_read_data1;
    idex_read_data2_d = bus.id_read_data2;
    idex_immediate_d  = ifid_instruction_q[15:0];
    idex_rs_d         = ifid_instruction_q[25:21];
    idex_rt_d         = ifid_instruction_q[20:16];
    idex_rd_d         = ifid_instruction_q[15:11];
  end

  // EX/MEM stage: only the memory and writeback control travels on
  always_comb begin
    exmem_reg_write_d  = idex_reg_write_q;
    exmem_mem_to_reg_d = idex_mem_to_reg_q;
    exmem_mem_read_d   = idex_mem_read_q;
    exmem_mem_write_d  = idex_mem_write_q;
    exmem_alu_result_d = bus.ex_alu_result;
    exmem_write_data_d = bus.ex_write_data;
    exmem_dest_reg_d   = bus.ex_dest_reg;
  end

  // Reset clears data as well as control: a zero word is a NOP and zero control is a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_instruction_q <= '0;
      ifid_pc4_q         <= '0;
      idex_reg_write_q   <= 1'b0;
      idex_mem_to_reg_q  <= 1'b0;
      idex_mem_read_q    <= 1'b0;
      idex_mem_write_q   <= 1'b0;
      idex_reg_dst_q     <= 1'b0;
      idex_alu_src_q     <= 1'b0;
      idex_branch_q      <= 1'b0;
      idex_alu_op_q      <= '0;
      idex_pc4_q         <= '0;
      idex_read_data1_q  <= '0;
      idex_read_data2_q  <= '0;
      idex_immediate_q   <= '0;
      idex_rs_q          <= '0;
      idex_rt_q          <= '0;
      idex_rd_q          <= '0;
      exmem_reg_write_q  <= 1'b0;
      exmem_mem_to_reg_q <= 1'b0;
      exmem_mem_read_q   <= 1'b0;
      exmem_mem_write_q  <= 1'b0;
      exmem_alu_result_q <= '0;
      exmem_write_data_q <= '0;
      exmem_dest_reg_q   <= '0;
    end else begin
      ifid_instruction_q <= ifid_instruction_d;
      ifid_pc4_q         <= ifid_pc4_d;
      idex_reg_write_q   <= idex_reg_write_d;
      idex_mem_to_reg_q  <= idex_mem_to_reg_d;
      idex_mem_read_q    <= idex_mem_read_d;
      idex_mem_write_q   <= idex_mem_write_d;
      idex_reg_dst_q     <= idex_reg_dst_d;
      idex_alu_src_q     <= idex_alu_src_d;
      idex_branch_q      <= idex_branch_d;
      idex_alu_op_q      <= idex_alu_op_d;
      idex_pc4_q         <= idex_pc4_d;
      idex_read_data1_q  <= idex_read_data1_d;
      idex_read_data2_q  <= idex_read_data2_d;
      idex_immediate_q   <= idex_immediate_d;
      idex_rs_q          <= idex_rs_d;
      idex_rt_q          <= idex_rt_d;
      idex_rd_q          <= idex_rd_d;
      exmem_reg_write_q  <= exmem_reg_write_d;
      exmem_mem_to_reg_q <= exmem_mem_to_reg_d;
      exmem_mem_read_q   <= exmem_mem_read_d;
      exmem_mem_write_q  <= exmem_mem_write_d;
      exmem_alu_result_q <= exmem_alu_result_d;
      exmem_write_data_q <= exmem_write_data_d;
      exmem_dest_reg_q   <= exmem_dest_reg_d;
    end
  end

  assign bus.ifid_instruction = ifid_instruction_q;
  assign bus.ifid_pc4         = ifid_pc4_q;
  assign bus.idex_reg_write   = idex_reg_write_q;
  assign bus.idex_mem_to_reg  = idex_mem_to_reg_q;
  assign bus.idex_mem_read    = idex_mem_read_q;
  assign bus.idex_mem_write   = idex_mem_write_q;
  assign bus.idex_reg_dst     = idex_reg_dst_q;
  assign bus.idex_alu_src     = idex_alu_src_q;
  assign bus.idex_branch      = idex_branch_q;
  assign bus.idex_alu_op      = idex_alu_op_q;
  assign bus.idex_pc4         = idex_pc4_q;
  assign bus.idex_read_data1  = idex_read_data1_q;
  assign bus.idex_read_data2  = idex_read_data2_q;
  assign bus.idex_immediate   = idex_immediate_q;
  assign bus.idex_rs          = idex_rs_q;
  assign bus.idex_rt          = idex_rt_q;
  assign bus.idex_rd          = idex_rd_q;
  assign bus.exmem_reg_write  = exmem_reg_write_q;
  assign bus.exmem_mem_to_reg = exmem_mem_to_reg_q;
  assign bus.exmem_mem_read   = exmem_mem_read_q;
  assign bus.exmem_mem_write  = exmem_mem_write_q;
  assign bus.exmem_alu_result = exmem_alu_result_q;
  assign bus.exmem_write_data = exmem_write_data_q;
  assign bus.exmem_dest_reg   = exmem_dest_reg_q;
endmodule

// File: tb/tb_pipeline_front_regs.sv
// Directed bench for pipeline_front_regs: per-edge vector table plus reset sequences.
module tb_pipeline_front_regs;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pipeline_front_regs_if bus ();

  pipeline_front_regs dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl packing: {reg_write, mem_to_reg, mem_read, mem_write, reg_dst, alu_src, branch, alu_op[1:0]}
  // exmem ctrl packing: {reg_write, mem_to_reg, mem_read, mem_write}
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        hold;
    logic [8:0]  ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  dest;
    logic [31:0] e_ifid_instr;
    logic [31:0] e_ifid_pc4;
    logic [8:0]  e_idex_ctrl;
    logic [31:0] e_idex_pc4;
    logic [31:0] e_idex_rd1;
    logic [31:0] e_idex_rd2;
    logic [15:0] e_imm;
    logic [4:0]  e_rs;
    logic [4:0]  e_rt;
    logic [4:0]  e_rd;
    logic [3:0]  e_exm_ctrl;
    logic [31:0] e_exm_alu;
    logic [31:0] e_exm_wd;
    logic [4:0]  e_exm_dest;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.if_instruction = v.instr;
    bus.if_pc4         = v.pc4;
    bus.ifid_hold      = v.hold;
    {bus.id_reg_write, bus.id_mem_to_reg, bus.id_mem_read, bus.id_mem_write,
     bus.id_reg_dst, bus.id_alu_src, bus.id_branch, bus.id_alu_op} = v.ctrl;
    bus.id_read_data1  = v.rd1;
    bus.id_read_data2  = v.rd2;
    bus.ex_alu_result  = v.alu;
    bus.ex_write_data  = v.wd;
    bus.ex_dest_reg    = v.dest;
  endtask

  function automatic logic any_out();
    logic [272:0] all;
    all = {bus.ifid_instruction, bus.ifid_pc4,
           bus.idex_reg_write, bus.idex_mem_to_reg, bus.idex_mem_read, bus.idex_mem_write,
           bus.idex_reg_dst, bus.idex_alu_src, bus.idex_branch, bus.idex_alu_op,
           bus.idex_pc4, bus.idex_read_data1, bus.idex_read_data2,
           bus.idex_immediate, bus.idex_rs, bus.idex_rt, bus.idex_rd,
           bus.exmem_reg_write, bus.exmem_mem_to_reg, bus.exmem_mem_read, bus.exmem_mem_write,
           bus.exmem_alu_result, bus.exmem_write_data, bus.exmem_dest_reg};
    return |all;
  endfunction

  task automatic chk_all_zero(input string name);
    chk(name, {31'd0, any_out()}, 32'd0);
  endtask

  task automatic chk_row(input int i);
    vec_t v;
    v = vecs[i];
    chk($sformatf("r%0d ifid_instruction", i), bus.ifid_instruction, v.e_ifid_instr);
    chk($sformatf("r%0d ifid_pc4", i), bus.ifid_pc4, v.e_ifid_pc4);
    chk($sformatf("r%0d idex_ctrl", i),
        {23'd0, bus.idex_reg_write, bus.idex_mem_to_reg, bus.idex_mem_read, bus.idex_mem_write,
         bus.idex_reg_dst, bus.idex_alu_src, bus.idex_branch, bus.idex_alu_op},
        {23'd0, v.e_idex_ctrl});
    chk($sformatf("r%0d idex_pc4", i), bus.idex_pc4, v.e_idex_pc4);
    chk($sformatf("r%0d idex_read_data1", i), bus.idex_read_data1, v.e_idex_rd1);
    chk($sformatf("r%0d idex_read_data2", i), bus.idex_read_data2, v.e_idex_rd2);
    chk($sformatf("r%0d idex_immediate", i), {16'd0, bus.idex_immediate}, {16'd0, v.e_imm});
    chk($sformatf("r%0d idex_rs_rt_rd", i), {17'd0, bus.idex_rs, bus.idex_rt, bus.idex_rd},
        {17'd0, v.e_rs, v.e_rt, v.e_rd});
    chk($sformatf("r%0d exmem_ctrl", i),
        {28'd0, bus.exmem_reg_write, bus.exmem_mem_to_reg, bus.exmem_mem_read, bus.exmem_mem_write},
        {28'd0, v.e_exm_ctrl});
    chk($sformatf("r%0d exmem_alu_result", i), bus.exmem_alu_result, v.e_exm_alu);
    chk($sformatf("r%0d exmem_write_data", i), bus.exmem_write_data, v.e_exm_wd);
    chk($sformatf("r%0d exmem_dest_reg", i), {27'd0, bus.exmem_dest_reg}, {27'd0, v.e_exm_dest});
  endtask

  initial begin
    vec_t junk;
    checks   = 0;
    failures = 0;

    // Rows: inputs before the edge, expected outputs after it. Rows 1-2 are the 2-cycle hold.
    vecs[0] = '{32'h012A4020, 32'h4, 1'b0, 9'h000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0,
                32'h012A4020, 32'h4, 9'h000, 32'h0, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0,
                4'b0000, 32'h0, 32'h0, 5'd0};
    vecs[1] = '{32'h8D090004, 32'h8, 1'b1, 9'h112, 32'h11, 32'h22, 32'h0, 32'h0, 5'd0,
                32'h012A4020, 32'h4, 9'h112, 32'h4, 32'h11, 32'h22, 16'h4020, 5'd9, 5'd10, 5'd8,
                4'b0000, 32'h0, 32'h0, 5'd0};
    vecs[2] = '{32'h8D090004, 32'h8, 1'b1, 9'h000, 32'h11, 32'h22, 32'h1E, 32'h22, 5'd8,
                32'h012A4020, 32'h4, 9'h000, 32'h4, 32'h11, 32'h22, 16'h4020, 5'd9, 5'd10, 5'd8,
                4'b1000, 32'h1E, 32'h22, 5'd8};
    vecs[3] = '{32'h8D090004, 32'h8, 1'b0, 9'h1C8, 32'h100, 32'h200, 32'h55, 32'h66, 5'd5,
                32'h8D090004, 32'h8, 9'h1C8, 32'h4, 32'h100, 32'h200, 16'h4020, 5'd9, 5'd10, 5'd8,
                4'b0000, 32'h55, 32'h66, 5'd5};
    vecs[4] = '{32'hAD2A0008, 32'hC, 1'b0, 9'h000, 32'h300, 32'h400, 32'h104, 32'h77, 5'd9,
                32'hAD2A0008, 32'hC, 9'h000, 32'h8, 32'h300, 32'h400, 16'h0004, 5'd8, 5'd9, 5'd0,
                4'b1110, 32'h104, 32'h77, 5'd9};
    vecs[5] = '{32'h0, 32'h10, 1'b0, 9'h028, 32'h5, 32'h6, 32'h7, 32'h8, 5'd0,
                32'h0, 32'h10, 9'h028, 32'hC, 32'h5, 32'h6, 16'h0008, 5'd9, 5'd10, 5'd0,
                4'b0000, 32'h7, 32'h8, 5'd0};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 1'b0, 9'h005, 32'hA, 32'hB, 32'hC, 32'hD, 5'd3,
                32'hFFFFFFFF, 32'hFFFFFFFC, 9'h005, 32'h10, 32'hA, 32'hB, 16'h0, 5'd0, 5'd0, 5'd0,
                4'b0001, 32'hC, 32'hD, 5'd3};
    vecs[7] = '{32'h0, 32'h0, 1'b0, 9'h000, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31,
                32'h0, 32'h0, 9'h000, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h0, 16'hFFFF, 5'd31, 5'd31, 5'd31,
                4'b0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31};

    // Power-up reset asserted asynchronously between edges with busy inputs
    junk = '{32'hDEADBEEF, 32'h1234, 1'b1, 9'h1FF, 32'hAAAA5555, 32'h5555AAAA, 32'h77, 32'h88, 5'd17,
             32'h0, 32'h0, 9'h0, 32'h0, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 4'h0, 32'h0, 32'h0, 5'd0};
    reset = 1'b1;
    drive(junk);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("reset_async_zero");
    tick();
    chk_all_zero("reset_held_edge1");
    tick();
    chk_all_zero("reset_held_edge2");

    drive(vecs[0]);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i]);
      tick();
      chk_row(i);
    end

    // Mid-run reset with all stages holding nonzero data
    drive(junk);
    #3;
    reset = 1'b0;
    #1;
    chk_all_zero("midrun_reset_zero");
    chk("midrun_exmem_alu", bus.exmem_alu_result, 32'h0);
    tick();
    chk_all_zero("midrun_reset_held");

    // Release: first edge with reset=1 loads IF/ID and the other stages
    drive(vecs[0]);
    bus.id_read_data1 = 32'hCAFE0001;
    bus.ex_dest_reg   = 5'd7;
    reset = 1'b1;
    tick();
    chk("release_ifid_instruction", bus.ifid_instruction, 32'h012A4020);
    chk("release_ifid_pc4", bus.ifid_pc4, 32'h4);
    chk("release_idex_pc4", bus.idex_pc4, 32'h0);
    chk("release_idex_read_data1", bus.idex_read_data1, 32'hCAFE0001);
    chk("release_exmem_dest_reg", {27'd0, bus.exmem_dest_reg}, {27'd0, 5'd7});
    tick();
    chk("release_idex_rd", {27'd0, bus.idex_rd}, {27'd0, 5'd8});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
